// File: rtl/axi_ram_slave.sv
// AXI3/4-style memory responder backed by a word-addressed internal RAM.
// Independent read and write engines, one outstanding transaction each, INCR bursts up to 16 beats.
module axi_ram_slave #(
  parameter int ADDR_W    = 10,
  parameter int READ_WAIT = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic [3:0]  r_wait;
  logic [2:0]  r_size;

  w_state_t    w_state;
  logic [31:0] w_addr;
  logic [3:0]  w_len;
  logic [3:0]  w_cnt;
  logic [2:0]  w_size;
  logic        w_fire;

  // Burst type, upper length bits, write ID and wlast carry no information for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{arlen[7:4], arburst, awburst, wid, wlast};

  assign rresp = 2'b00;
  assign bresp = 2'b00;

  // Read data is an asynchronous lookup of the registered beat address, so a same-cycle
  // write is seen only from the following cycle.
  assign rdata = rvalid ? mem[r_addr[ADDR_W+1:2]] : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= 4'd0;
      r_addr  <= 32'd0;
      r_len   <= 4'd0;
      r_cnt   <= 4'd0;
      r_wait  <= 4'd0;
      r_size  <= 3'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen[3:0];
            r_size  <= arsize;
            r_cnt   <= 4'd0;
            r_wait  <= 4'd0;
            if (READ_WAIT > 0) begin
              r_state <= R_WAIT;
            end else begin
              r_state <= R_DATA;
              rvalid  <= 1'b1;
              rlast   <= (arlen[3:0] == 4'd0);
            end
          end
        end
        R_WAIT: begin
          if (r_wait == 4'(READ_WAIT - 1)) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rlast   <= (r_len == 4'd0);
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_addr + (32'd1 << r_size);
              r_cnt  <= r_cnt + 4'd1;
              rlast  <= ((r_cnt + 4'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign w_fire = (w_state == W_DATA) && wvalid && wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= 4'd0;
      w_addr  <= 32'd0;
      w_len   <= 4'd0;
      w_cnt   <= 4'd0;
      w_size  <= 3'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          wready  <= 1'b0;
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            bid     <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_cnt   <= 4'd0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= w_addr + (32'd1 << w_size);
            w_cnt  <= w_cnt + 4'd1;
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr[ADDR_W+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: instance 0 uses READ_WAIT=0, instance 1 uses READ_WAIT=5.
// Both share clock and reset; all expected values are hand-computed constants.
module tb_axi_ram_slave;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  arid    [2];
  logic [31:0] araddr  [2];
  logic [7:0]  arlen   [2];
  logic [2:0]  arsize  [2];
  logic [1:0]  arburst [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [3:0]  rid     [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rlast   [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [3:0]  awid    [2];
  logic [31:0] awaddr  [2];
  logic [3:0]  awlen   [2];
  logic [2:0]  awsize  [2];
  logic [1:0]  awburst [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [3:0]  wid     [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        wlast   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [3:0]  bid     [2];
  logic [1:0]  bresp   [2];
  logic        bvalid  [2];
  logic        bready  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      axi_ram_slave #(.ADDR_W(10), .READ_WAIT(gi * 5)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid[gi]), .araddr(araddr[gi]), .arlen(arlen[gi]), .arsize(arsize[gi]),
        .arburst(arburst[gi]), .arvalid(arvalid[gi]), .arready(arready[gi]),
        .rid(rid[gi]), .rdata(rdata[gi]), .rresp(rresp[gi]), .rlast(rlast[gi]),
        .rvalid(rvalid[gi]), .rready(rready[gi]),
        .awid(awid[gi]), .awaddr(awaddr[gi]), .awlen(awlen[gi]), .awsize(awsize[gi]),
        .awburst(awburst[gi]), .awvalid(awvalid[gi]), .awready(awready[gi]),
        .wid(wid[gi]), .wdata(wdata[gi]), .wstrb(wstrb[gi]), .wlast(wlast[gi]),
        .wvalid(wvalid[gi]), .wready(wready[gi]),
        .bid(bid[gi]), .bresp(bresp[gi]), .bvalid(bvalid[gi]), .bready(bready[gi])
      );
    end
  endgenerate

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_aw(input int k, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [2:0] size);
    int n = 0;
    @(negedge clk);
    awid[k] = id; awaddr[k] = addr; awlen[k] = len; awsize[k] = size; awvalid[k] = 1'b1;
    while (!awready[k] && n < 20) begin @(negedge clk); n++; end
    chk("aw_ready", 32'(awready[k]), 32'd1);
    @(posedge clk); #1;
    awvalid[k] = 1'b0;
  endtask

  task automatic do_w(input int k, input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata[k] = data; wstrb[k] = strb; wlast[k] = last; wvalid[k] = 1'b1;
    @(negedge clk);
    while (!wready[k] && n < 20) begin @(negedge clk); n++; end
    chk("w_ready", 32'(wready[k]), 32'd1);
    @(posedge clk); #1;
    wvalid[k] = 1'b0; wlast[k] = 1'b0;
  endtask

  task automatic do_b(input int k, input logic [3:0] id);
    int n = 0;
    @(negedge clk);
    while (!bvalid[k] && n < 20) begin @(negedge clk); n++; end
    chk("b_lat", 32'(n), 32'd0);
    chk("b_valid", 32'(bvalid[k]), 32'd1);
    chk("b_id", 32'(bid[k]), 32'(id));
    chk("b_resp", 32'(bresp[k]), 32'd0);
    bready[k] = 1'b1;
    @(posedge clk); #1;
    bready[k] = 1'b0;
    chk("b_drop", 32'(bvalid[k]), 32'd0);
  endtask

  task automatic do_ar(input int k, input logic [3:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    @(negedge clk);
    arid[k] = id; araddr[k] = addr; arlen[k] = len; arsize[k] = size; arvalid[k] = 1'b1;
    while (!arready[k] && n < 20) begin @(negedge clk); n++; end
    chk("ar_ready", 32'(arready[k]), 32'd1);
    @(posedge clk); #1;
    arvalid[k] = 1'b0;
  endtask

  task automatic write_burst(input int k, input logic [3:0] id, input logic [31:0] addr,
                             input int len, input logic [31:0] base);
    do_aw(k, id, addr, 4'(len), 3'd2);
    for (int i = 0; i <= len; i++) do_w(k, base + 32'(i), 4'hF, i == len);
    do_b(k, id);
    $display("dut%0d write addr=%h beats=%0d base=%h", k, addr, len + 1, base);
  endtask

  // Reads len+1 beats and compares against exp_q; lat is the expected number of
  // falling edges from the AR handshake to the first visible rvalid.
  task automatic read_burst(input int k, input logic [3:0] id, input logic [31:0] addr,
                            input int len, input bit toggle, input int lat);
    int beat = 0;
    int cyc = 0;
    int guard = 0;
    bit seen = 1'b0;
    do_ar(k, id, addr, 8'(len), 3'd2);
    while (beat <= len && guard < 100) begin
      @(negedge clk);
      guard++;
      if (rvalid[k]) begin
        if (!seen) begin
          seen = 1'b1;
          chk("r_lat", 32'(guard), 32'(lat));
        end
        rready[k] = toggle ? (cyc % 2 == 0) : 1'b1;
        cyc++;
        chk("r_data", rdata[k], exp_q[beat]);
        chk("r_last", 32'(rlast[k]), 32'(beat == len));
        chk("r_id", 32'(rid[k]), 32'(id));
        chk("r_resp", 32'(rresp[k]), 32'd0);
        if (rready[k]) beat++;
      end else begin
        rready[k] = 1'b0;
      end
    end
    @(posedge clk); #1;
    rready[k] = 1'b0;
    chk("r_beats", 32'(beat), 32'(len + 1));
    chk("r_end", 32'(rvalid[k]), 32'd0);
    $display("dut%0d read addr=%h beats=%0d", k, addr, len + 1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      arid[k] = 0; araddr[k] = 0; arlen[k] = 0; arsize[k] = 0; arburst[k] = 2'b01; arvalid[k] = 0;
      rready[k] = 0;
      awid[k] = 0; awaddr[k] = 0; awlen[k] = 0; awsize[k] = 0; awburst[k] = 2'b01; awvalid[k] = 0;
      wid[k] = 0; wdata[k] = 0; wstrb[k] = 0; wlast[k] = 0; wvalid[k] = 0; bready[k] = 0;
    end

    // Reset and release
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready[0]), 32'd0);
    chk("rst_awready", 32'(awready[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_arready", 32'(arready[0]), 32'd1);
    chk("rel_awready", 32'(awready[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("idle_rvalid", 32'(rvalid[0]), 32'd0);
    chk("idle_bvalid", 32'(bvalid[0]), 32'd0);
    $display("reset released");

    // Single write with an early wvalid that must be held off, then read back
    wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    @(negedge clk);
    chk("early_wready", 32'(wready[0]), 32'd0);
    do_aw(0, 4'd3, 32'h1FC0_0010, 4'd0, 3'd2);
    do_w(0, 32'hDEADBEEF, 4'hF, 1'b1);
    do_b(0, 4'd3);
    $display("dut0 single write 1fc00010 = deadbeef");
    exp_q[0] = 32'hDEADBEEF;
    read_burst(0, 4'd5, 32'h1FC0_0010, 0, 1'b0, 1);
    read_burst(0, 4'd6, 32'h0000_0010, 0, 1'b0, 1);

    // Byte strobes
    do_aw(0, 4'd1, 32'h40, 4'd0, 3'd2);
    do_w(0, 32'h11223344, 4'hF, 1'b1);
    do_b(0, 4'd1);
    do_aw(0, 4'd2, 32'h40, 4'd0, 3'd2);
    do_w(0, 32'hAABBCCDD, 4'b0101, 1'b1);
    do_b(0, 4'd2);
    exp_q[0] = 32'h11BB33DD;
    read_burst(0, 4'd7, 32'h40, 0, 1'b0, 1);

    // Narrow byte burst filling one word lane by lane
    do_aw(0, 4'd4, 32'h200, 4'd3, 3'd0);
    do_w(0, 32'h000000A1, 4'b0001, 1'b0);
    do_w(0, 32'h0000B200, 4'b0010, 1'b0);
    do_w(0, 32'h00C30000, 4'b0100, 1'b0);
    do_w(0, 32'hD4000000, 4'b1000, 1'b1);
    do_b(0, 4'd4);
    exp_q[0] = 32'hD4C3B2A1;
    read_burst(0, 4'd8, 32'h200, 0, 1'b0, 1);

    // INCR burst with a stalling master
    write_burst(0, 4'd9, 32'h100, 3, 32'd1);
    for (int i = 0; i < 4; i++) exp_q[i] = 32'(i + 1);
    read_burst(0, 4'd10, 32'h100, 3, 1'b1, 1);

    // READ_WAIT=5 read concurrent with a write burst
    write_burst(1, 4'd1, 32'h300, 3, 32'h50);
    for (int i = 0; i < 4; i++) exp_q[i] = 32'h50 + 32'(i);
    fork
      read_burst(1, 4'd2, 32'h300, 3, 1'b0, 6);
      write_burst(1, 4'd3, 32'h380, 3, 32'h60);
    join
    for (int i = 0; i < 4; i++) exp_q[i] = 32'h60 + 32'(i);
    read_burst(1, 4'd4, 32'h380, 3, 1'b0, 6);

    // Reset during beat 2 of an 8-beat read
    write_burst(0, 4'd1, 32'h180, 7, 32'h70);
    do_ar(0, 4'd2, 32'h180, 8'd7, 3'd2);
    rready[0] = 1'b1;
    @(negedge clk);
    chk("mid_beat0", rdata[0], 32'h70);
    @(negedge clk);
    chk("mid_beat1", rdata[0], 32'h71);
    @(negedge clk);
    chk("mid_beat2", rdata[0], 32'h72);
    resetn = 1'b0;
    #1;
    chk("mid_rvalid", 32'(rvalid[0]), 32'd0);
    chk("mid_rlast", 32'(rlast[0]), 32'd0);
    rready[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_arready_rst", 32'(arready[0]), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("mid_arready_rel", 32'(arready[0]), 32'd1);
    repeat (3) @(negedge clk);
    chk("mid_no_rvalid", 32'(rvalid[0]), 32'd0);
    $display("dut0 reset mid-burst");
    exp_q[0] = 32'h70;
    exp_q[1] = 32'h71;
    read_burst(0, 4'd3, 32'h180, 1, 1'b0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
